// File: rtl/rf_sequencer_pkg.sv
// Shared opcodes, FSM encoding and instruction field layout for the register file sequencer.
package rf_seq_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned REG_W   = 3;
  localparam int unsigned IMM_W   = 8;

  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RA_LSB  = 6;
  localparam int unsigned RB_LSB  = 3;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [OP_W-1:0] OP_ADD = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB = 4'h1;
  localparam logic [OP_W-1:0] OP_AND = 4'h2;
  localparam logic [OP_W-1:0] OP_OR  = 4'h3;
  localparam logic [OP_W-1:0] OP_XOR = 4'h4;
  localparam logic [OP_W-1:0] OP_SHL = 4'h5;
  localparam logic [OP_W-1:0] OP_SHR = 4'h6;
  localparam logic [OP_W-1:0] OP_LI  = 4'h7;
  localparam logic [OP_W-1:0] OP_MOV = 4'h8;
  localparam logic [OP_W-1:0] OP_CMP = 4'h9;
  localparam logic [OP_W-1:0] OP_NOP = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

endpackage

// File: rtl/rf_sequencer_if.sv
// Instruction handshake plus register file initiator bus; master is the sequencer.
interface rf_sequencer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SEL_W  = 3
);
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic              en;
  logic              we;
  logic [SEL_W-1:0]  sel_a;
  logic [SEL_W-1:0]  sel_b;
  logic [SEL_W-1:0]  sel_d;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic              done;
  logic              illegal;
  logic              zero;

  modport master (
    input  instr_valid, instr, data_a, data_b,
    output instr_ready, en, we, sel_a, sel_b, sel_d, data_d, done, illegal, zero
  );

  modport slave (
    output instr_valid, instr, data_a, data_b,
    input  instr_ready, en, we, sel_a, sel_b, sel_d, data_d, done, illegal, zero
  );
endinterface

// File: rtl/rf_sequencer_alu.sv
// Combinational ALU: opcode and operands to result, write-back flag and illegal flag.
module rf_alu
  import rf_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [IMM_W-1:0]  imm8,
  output logic [DATA_W-1:0] result,
  output logic              writes,
  output logic              illegal
);

  always_comb begin
    result  = '0;
    writes  = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_ADD: begin result = a + b;          writes = 1'b1; end
      OP_SUB: begin result = a - b;          writes = 1'b1; end
      OP_AND: begin result = a & b;          writes = 1'b1; end
      OP_OR:  begin result = a | b;          writes = 1'b1; end
      OP_XOR: begin result = a ^ b;          writes = 1'b1; end
      OP_SHL: begin result = a << b[3:0];    writes = 1'b1; end
      OP_SHR: begin result = a >> b[3:0];    writes = 1'b1; end
      OP_LI:  begin result = DATA_W'(imm8);  writes = 1'b1; end
      OP_MOV: begin result = a;              writes = 1'b1; end
      OP_CMP: result = a - b;
      OP_NOP: result = '0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rf_sequencer.sv
// Single-issue sequencer: accept, read operands, execute, write back to a negedge register file.
module rf_sequencer
  import rf_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SEL_W  = 3
) (
  input  logic           I_clk,
  input  logic           I_rst_n,
  rf_sequencer_if.master bus
);

  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [IMM_W-1:0]    imm_q, imm_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic                ready_q, ready_d, en_q, en_d, we_q, we_d;
  logic                done_q, done_d, illegal_q, illegal_d, zero_q, zero_d;
  logic [SEL_W-1:0]    sel_a_q, sel_a_d, sel_b_q, sel_b_d, sel_d_q, sel_d_d;
  logic [DATA_W-1:0]   data_d_q, data_d_d;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_writes, alu_illegal;

  rf_alu #(.DATA_W(DATA_W)) u_alu (
    .op      (op_q),
    .a       (op_a_q),
    .b       (op_b_q),
    .imm8    (imm_q),
    .result  (alu_result),
    .writes  (alu_writes),
    .illegal (alu_illegal)
  );

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      imm_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      ready_q   <= 1'b1;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      zero_q    <= 1'b0;
      sel_a_q   <= '0;
      sel_b_q   <= '0;
      sel_d_q   <= '0;
      data_d_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      imm_q     <= imm_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      ready_q   <= ready_d;
      en_q      <= en_d;
      we_q      <= we_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      zero_q    <= zero_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      sel_d_q   <= sel_d_d;
      data_d_q  <= data_d_d;
    end
  end

  // Outputs are computed for the state being entered so every port comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    imm_d     = imm_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    ready_d   = 1'b0;
    en_d      = 1'b0;
    we_d      = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    zero_d    = zero_q;
    sel_a_d   = sel_a_q;
    sel_b_d   = sel_b_q;
    sel_d_d   = sel_d_q;
    data_d_d  = data_d_q;
    case (state_q)
      IDLE: begin
        if (bus.instr_valid && ready_q) begin
          state_d = READ;
          op_d    = bus.instr[OP_LSB +: OP_W];
          imm_d   = bus.instr[IMM_LSB +: IMM_W];
          sel_a_d = SEL_W'(bus.instr[RA_LSB +: REG_W]);
          sel_b_d = SEL_W'(bus.instr[RB_LSB +: REG_W]);
          sel_d_d = SEL_W'(bus.instr[RD_LSB +: REG_W]);
          en_d    = 1'b1;
        end else begin
          ready_d = 1'b1;
        end
      end
      READ: begin
        state_d = EXEC;
        op_a_d  = bus.data_a;
        op_b_d  = bus.data_b;
      end
      EXEC: begin
        data_d_d = alu_result;
        if (alu_writes || (op_q == OP_CMP)) zero_d = (alu_result == '0);
        if (alu_writes) begin
          state_d = WB;
          en_d    = 1'b1;
          we_d    = 1'b1;
        end else begin
          state_d   = IDLE;
          done_d    = 1'b1;
          illegal_d = alu_illegal;
          ready_d   = 1'b1;
        end
      end
      WB: begin
        state_d = IDLE;
        done_d  = 1'b1;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  assign bus.instr_ready = ready_q;
  assign bus.en          = en_q;
  assign bus.we          = we_q;
  assign bus.sel_a       = sel_a_q;
  assign bus.sel_b       = sel_b_q;
  assign bus.sel_d       = sel_d_q;
  assign bus.data_d      = data_d_q;
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;
  assign bus.zero        = zero_q;

endmodule

// File: doc/rf_sequencer.md
Name: rf_sequencer

Overview:
Single-issue instruction sequencer and the initiator side of the 8x16 register file interface. It accepts one 16-bit instruction per handshake and decodes the fields. It drives the register file read selects, captures operands, executes a small ALU op and drives the write-back port (selD/dataD/we/en). It sits between instruction fetch and the negedge-clocked register file.

Parameters:
DATA_W, 16, operand/result width
SEL_W, 3, register select width (2**SEL_W registers)

Ports:
I_clk  in  1  clock; state updates on posedge, register file samples on negedge
I_rst_n  in  1  asynchronous active-low reset
I_instr_valid  in  1  instruction present
o_instr_ready  out  1  sequencer can accept (high only in IDLE)
I_instr  in  16  instruction: [15:12] opcode, [11:9] rD, [8:6] rA, [5:3] rB, [7:0] imm8
o_en  out  1  register file enable
o_we  out  1  register file write enable
o_selA  out  SEL_W  read select A
o_selB  out  SEL_W  read select B
o_selD  out  SEL_W  write select
o_dataD  out  DATA_W  write-back data
I_dataA  in  DATA_W  register file read data A
I_dataB  in  DATA_W  register file read data B
o_done  out  1  one-cycle pulse when the instruction retires
o_illegal  out  1  one-cycle pulse with o_done for an undefined opcode
o_zero  out  1  zero flag, sticky between updating ops

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - o_en, o_we, o_done, o_illegal, o_zero = 0.
  - All selects = 0; o_dataD = 0.
  - o_instr_ready = 1.
- Handshake:
  - Accept on a posedge with I_instr_valid & o_instr_ready; the instruction is latched internally.
  - The source holds I_instr while valid & !ready.
  - Valid during busy states is ignored.
- States: IDLE -> READ -> EXEC -> WB -> IDLE; non-writing ops go EXEC -> IDLE.
- IDLE: ready=1, o_en=0, o_we=0; on accept -> READ.
- READ (1 cycle):
  - o_en=1, o_we=0.
  - o_selA=rA, o_selB=rB, o_selD=rD (held through WB).
  - The register file loads I_dataA/I_dataB at that cycle's negedge.
  - At the next posedge, operands are captured from I_dataA/I_dataB -> EXEC.
- EXEC (1 cycle): o_en=0.
  - At posedge, the result is registered into o_dataD.
  - o_zero updates for writing ops and CMP.
  - Writing ops -> WB; others -> IDLE with o_done=1.
- WB (1 cycle):
  - o_en=1, o_we=1; the register file writes at the negedge.
  - Next posedge -> IDLE with o_done=1.
- Latency: accept at posedge N gives o_done high in cycle N+3..N+4 (writing ops) or N+2..N+3 (CMP/NOP/illegal).
  - A new instruction may be accepted in the same cycle o_done is high.
  - Throughput is 1 per 4 cycles.
- Opcodes (all arithmetic modulo 2**DATA_W, unsigned):
  - 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR.
  - 5 SHL A<<B[3:0]; 6 SHR (logical) A>>B[3:0].
  - 7 LI rD={8'h00,imm8}; 8 MOV rD=A.
  - 9 CMP: zero=(A-B==0), no write.
  - F NOP: no write, zero held.
  - A-E illegal: no write, zero held, o_illegal pulses with o_done.
- rD=rA/rB is legal: operands are captured before write-back, so the old value is used.
- Reset mid-operation: returns to IDLE at once and o_en/o_we drop. A write is aborted if reset asserts before the WB negedge.

Decomposition:
- Package rf_seq_pkg holds:
  - opcode localparams OP_ADD..OP_NOP;
  - state encoding IDLE/READ/EXEC/WB;
  - field bit positions for opcode/rD/rA/rB/imm8.
- Sub-module rf_alu is purely combinational: opcode, A, B, imm8 -> result, writes, illegal.
- rf_sequencer holds the FSM and the registers.

Test Plan:
- Reset and idle: reset with no instruction -> all outputs 0, ready=1, no o_en activity.
- LI then ADD against the real 8x16 register file model:
  - LI r1=0x12, LI r2=0x34, ADD r3=r1+r2 -> r3=0x0046, o_zero=0.
  - Each o_done lands exactly 4 cycles after its accept.
- Wrap and zero flag:
  - r1=0xFFFF (LI 0xFF, then SHL/OR sequence), r2=0x0001, ADD r4 -> r4=0x0000, o_zero=1.
  - SUB r5=r4-r2 -> 0xFFFF, o_zero=0.
- Non-writing ops:
  - CMP r1,r1 -> o_zero=1, o_we never high, o_done 3 cycles after accept.
  - Opcode 0xC -> o_illegal and o_done pulse together, no register changes.
- Back-to-back and busy handshake:
  - valid held high for 3 queued instructions -> accepts only in IDLE cycles, exactly 3 o_done pulses.
  - Changing I_instr while ready=0 has no effect.
- Reset mid-WB:
  - Assert I_rst_n low during WB before the negedge -> target register unchanged, outputs at reset values, next instruction executes normally.
